// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller:
// opcodes, function fields, ALU codes, mux selects and FSM states.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    StRstIdle = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StRWb     = 4'd4,
    StAddr    = 4'd5,
    StMemRd   = 4'd6,
    StLoadWb  = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StHalt    = 4'd10
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// R-type function decode: maps funct7/funct3 to an ALU operation and
// reports whether the combination is one of the supported R-type ops.
module alu_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] aluctrl,
  output logic       r_legal
);

  always_comb begin
    aluctrl = ALU_ADD;
    r_legal = 1'b0;
    case (funct3)
      F3_ADD_SUB: begin
        if (funct7 == F7_BASE) begin
          aluctrl = ALU_ADD;
          r_legal = 1'b1;
        end else if (funct7 == F7_SUB) begin
          aluctrl = ALU_SUB;
          r_legal = 1'b1;
        end
      end
      F3_OR: begin
        aluctrl = ALU_OR;
        r_legal = (funct7 == F7_BASE);
      end
      F3_AND: begin
        aluctrl = ALU_AND;
        r_legal = (funct7 == F7_BASE);
      end
      default: begin
        aluctrl = ALU_ADD;
        r_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for a shared-ALU, single-memory RV32I-subset core
// (add, sub, and, or, lw, sw, beq) with a variable-latency memory handshake.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        memread,
  output logic        memwrite,
  output logic        iord,
  output logic        irwrite,
  output logic        pc_we,
  output logic        pcsource,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [3:0]  aluctrl,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        retire,
  output logic        illegal,
  output logic [3:0]  state
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] r_aluctrl;
  logic       r_legal;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register/immediate fields belong to the datapath, not the controller.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  alu_decode u_alu_decode (
    .funct7  (funct7),
    .funct3  (funct3),
    .aluctrl (r_aluctrl),
    .r_legal (r_legal)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StRstIdle: state_d = StFetch;
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (opcode == OP_R && r_legal) begin
          state_d = StExecR;
        end else if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == F3_WORD) begin
          state_d = StAddr;
        end else if (opcode == OP_BRANCH && funct3 == F3_BEQ) begin
          state_d = StBranch;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StExecR:  state_d = StRWb;
      StRWb:    state_d = StFetch;
      StAddr:   state_d = (opcode == OP_LOAD) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StLoadWb;
      StLoadWb: state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StBranch: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StRstIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRstIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pc_we    = 1'b0;
    pcsource = 1'b0;
    alusrca  = SRCA_PC;
    alusrcb  = SRCB_REG;
    aluctrl  = ALU_AND;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    retire   = 1'b0;
    case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrca = SRCA_PC;
        alusrcb = SRCB_FOUR;
        aluctrl = ALU_ADD;
        irwrite = mem_ready;
        pc_we   = mem_ready;
      end
      StDecode: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        aluctrl = ALU_ADD;
      end
      StExecR: begin
        alusrca = SRCA_REG;
        alusrcb = SRCB_REG;
        aluctrl = r_aluctrl;
      end
      StRWb: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      StAddr: begin
        alusrca = SRCA_REG;
        alusrcb = SRCB_IMM;
        aluctrl = ALU_ADD;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StLoadWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      StMemWr: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        retire   = mem_ready;
      end
      StBranch: begin
        alusrca  = SRCA_REG;
        alusrcb  = SRCB_REG;
        aluctrl  = ALU_SUB;
        pcsource = 1'b1;
        pc_we    = zero;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle expected control word is
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        memread, memwrite, iord, irwrite, pc_we, pcsource;
  logic [1:0]  alusrca, alusrcb;
  logic [3:0]  aluctrl;
  logic        regwrite, memtoreg, retire, illegal;
  logic [3:0]  state;

  int compared = 0;
  int mismatched = 0;
  logic [21:0] sb[$];

  multicycle_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .memread   (memread),
    .memwrite  (memwrite),
    .iord      (iord),
    .irwrite   (irwrite),
    .pc_we     (pc_we),
    .pcsource  (pcsource),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluctrl   (aluctrl),
    .regwrite  (regwrite),
    .memtoreg  (memtoreg),
    .retire    (retire),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Packed word: state, memread, memwrite, iord, irwrite, pc_we, pcsource,
  // alusrca, alusrcb, aluctrl, regwrite, memtoreg, retire, illegal.
  function automatic logic [21:0] model(input logic [3:0] st, input logic rdy, input logic z,
                                        input logic [3:0] rop, input logic ill);
    logic mr = 0, mw = 0, io = 0, irw = 0, pw = 0, ps = 0, rw = 0, m2r = 0, ret = 0;
    logic [1:0] sa = 2'b00, sbs = 2'b00;
    logic [3:0] op = 4'b0000;
    case (st)
      4'd1:  begin mr = 1; sbs = 2'b01; op = 4'b0010; irw = rdy; pw = rdy; end
      4'd2:  begin sa = 2'b10; sbs = 2'b10; op = 4'b0010; end
      4'd3:  begin sa = 2'b01; sbs = 2'b00; op = rop; end
      4'd4:  begin rw = 1; ret = 1; end
      4'd5:  begin sa = 2'b01; sbs = 2'b10; op = 4'b0010; end
      4'd6:  begin mr = 1; io = 1; end
      4'd7:  begin rw = 1; m2r = 1; ret = 1; end
      4'd8:  begin mw = 1; io = 1; ret = rdy; end
      4'd9:  begin sa = 2'b01; op = 4'b0110; ps = 1; pw = z; ret = 1; end
      default: ;
    endcase
    return {st, mr, mw, io, irw, pw, ps, sa, sbs, op, rw, m2r, ret, ill};
  endfunction

  function automatic logic [21:0] observed();
    return {state, memread, memwrite, iord, irwrite, pc_we, pcsource, alusrca, alusrcb,
            aluctrl, regwrite, memtoreg, retire, illegal};
  endfunction

  task automatic compare_now(input string tag);
    logic [21:0] exp_w, obs_w;
    exp_w = sb.pop_front();
    obs_w = observed();
    compared++;
    assert (obs_w === exp_w) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs_w, exp_w);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, check at negedge.
  task automatic step(input logic [3:0] st, input logic rdy, input logic z,
                      input logic [3:0] rop, input logic ill, input string tag);
    mem_ready = rdy;
    zero      = z;
    sb.push_back(model(st, rdy, z, rop, ill));
    @(negedge clk);
    compare_now(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_r(input logic [31:0] ins, input logic [3:0] rop, input string tag);
    instr = ins;
    step(4'd1, 1, 0, 0, 0, {tag, "_fetch"});
    step(4'd2, 1, 0, 0, 0, {tag, "_decode"});
    step(4'd3, 1, 1, rop, 0, {tag, "_exec"});
    step(4'd4, 1, 0, 0, 0, {tag, "_wb"});
  endtask

  initial begin
    step(4'd0, 1, 0, 0, 0, "in_reset_a");
    step(4'd0, 0, 1, 0, 0, "in_reset_b");
    rst_n = 1'b1;
    step(4'd0, 1, 0, 0, 0, "first_after_release");

    run_r(32'h002081B3, 4'b0010, "add");
    run_r(32'h402081B3, 4'b0110, "sub");
    run_r(32'h0020E1B3, 4'b0001, "or");
    run_r(32'h0020F1B3, 4'b0000, "and");

    instr = 32'h0080A283;
    step(4'd1, 1, 0, 0, 0, "lw_fetch");
    step(4'd2, 0, 0, 0, 0, "lw_decode");
    step(4'd5, 1, 0, 0, 0, "lw_addr");
    step(4'd6, 0, 0, 0, 0, "lw_memrd_w1");
    step(4'd6, 0, 0, 0, 0, "lw_memrd_w2");
    step(4'd6, 1, 0, 0, 0, "lw_memrd_done");
    step(4'd7, 0, 0, 0, 0, "lw_wb");

    instr = 32'h0050A423;
    for (int i = 0; i < 3; i++) step(4'd1, 0, 0, 0, 0, "sw_fetch_wait");
    step(4'd1, 1, 0, 0, 0, "sw_fetch");
    step(4'd2, 1, 0, 0, 0, "sw_decode");
    step(4'd5, 0, 0, 0, 0, "sw_addr");
    step(4'd8, 0, 0, 0, 0, "sw_memwr_wait");
    step(4'd8, 1, 0, 0, 0, "sw_memwr_done");

    instr = 32'h00208863;
    step(4'd1, 1, 0, 0, 0, "beq1_fetch");
    step(4'd2, 1, 0, 0, 0, "beq1_decode");
    step(4'd9, 0, 1, 0, 0, "beq_taken");
    step(4'd1, 1, 0, 0, 0, "beq0_fetch");
    step(4'd2, 1, 0, 0, 0, "beq0_decode");
    step(4'd9, 1, 0, 0, 0, "beq_not_taken");

    instr = 32'h0080A283;
    step(4'd1, 1, 0, 0, 0, "lwr_fetch");
    step(4'd2, 1, 0, 0, 0, "lwr_decode");
    step(4'd5, 1, 0, 0, 0, "lwr_addr");
    step(4'd6, 0, 0, 0, 0, "lwr_memrd_wait");
    mem_ready = 1'b0;
    #1;
    sb.push_back(model(4'd6, 0, 0, 0, 0));
    compare_now("lwr_memrd_held");
    rst_n = 1'b0;
    #1;
    sb.push_back(model(4'd0, 0, 0, 0, 0));
    compare_now("lwr_async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'd0, 1, 0, 0, 0, "lwr_idle_after_reset");

    instr = 32'h00000013;
    step(4'd1, 1, 0, 0, 0, "addi_fetch");
    step(4'd2, 1, 0, 0, 0, "addi_decode");
    for (int i = 0; i < 12; i++) begin
      step(4'd10, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 1, "halt_hold");
    end
    rst_n = 1'b0;
    #1;
    sb.push_back(model(4'd0, 0, 0, 0, 0));
    compare_now("halt_reset_clears");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I subset core (add, sub, and, or, lw, sw, beq). It sequences a shared-ALU, single-memory datapath one instruction at a time through fetch, decode, execute, memory and writeback. It drives the PC, IR and register-file write enables, the ALU operand muxes and the ALU operation. It handshakes with a variable-latency memory port and flags unsupported instructions.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  32  current IR contents; valid from DECODE onward.
- zero  in  1  ALU zero flag; combinational from the current ALU operation.
- mem_ready  in  1  memory completes the current request in this cycle.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  IR load enable.
- pc_we  out  1  PC write enable, already qualified with zero for beq.
- pcsource  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- alusrca  out  2  ALU A select: 00 = PC, 01 = rs1 register A, 10 = oldPC.
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = immediate.
- aluctrl  out  4  ALU operation: 0000 = AND, 0001 = OR, 0010 = ADD, 0110 = SUB.
- regwrite  out  1  register-file write enable.
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- retire  out  1  one-cycle pulse in the last cycle of each completed instruction.
- illegal  out  1  sticky flag for an unsupported instruction.
- state  out  4  current state encoding, for debug.

## Operation
- States: RST_IDLE, FETCH, DECODE, EXEC_R, R_WB, ADDR, MEM_RD, LOAD_WB, MEM_WR, BRANCH, HALT.
- Any output not listed for a state is 0.
- RST_IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH: memread=1, iord=0, alusrca=00, alusrcb=01, aluctrl=ADD, pcsource=0.
  - When mem_ready=1: irwrite=1, pc_we=1, go to DECODE.
  - Otherwise stay in FETCH with irwrite=0 and pc_we=0.
- DECODE: alusrca=10, alusrcb=10, aluctrl=ADD (branch target into ALUOut). Next state by instruction:
  - opcode 0110011 with funct7 0000000 and funct3 000/110/111, or funct7 0100000 and funct3 000: EXEC_R.
  - opcode 0000011 or 0100011 with funct3 010: ADDR.
  - opcode 1100011 with funct3 000: BRANCH.
  - Anything else: HALT, and set illegal.
- EXEC_R: alusrca=01, alusrcb=00, aluctrl decoded from funct7/funct3: add = ADD, sub = SUB, funct3 110 = OR, funct3 111 = AND. Go to R_WB.
- R_WB: regwrite=1, memtoreg=0, retire=1. Go to FETCH.
- ADDR: alusrca=01, alusrcb=10, aluctrl=ADD. Go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: memread=1, iord=1. Go to LOAD_WB on mem_ready; the datapath latches MDR every cycle.
- LOAD_WB: regwrite=1, memtoreg=1, retire=1. Go to FETCH.
- MEM_WR: memwrite=1, iord=1. When mem_ready=1: retire=1, go to FETCH.
- BRANCH: alusrca=01, alusrcb=00, aluctrl=SUB, pcsource=1, pc_we=zero, retire=1. Go to FETCH.
- HALT: all outputs 0 except illegal=1. Stays in HALT until reset.

## Timing
- Outputs are a Moore decode of the state register. The only Mealy terms are irwrite/pc_we in FETCH (qualified by mem_ready), pc_we in BRANCH (zero), and retire in MEM_WR (mem_ready).
- Reset: state goes to RST_IDLE asynchronously and illegal clears. Every output reads 0 while in reset and in the first cycle after release.
- Memory handshake:
  - A request stays asserted, with stable iord, until the cycle in which mem_ready=1; the transfer completes in that cycle.
  - mem_ready is ignored in states with no request.
  - The controller never drops a request on its own; only reset aborts one.
- Zero-wait latency in cycles: beq 3, R-type 4, sw 4, lw 5. Each wait cycle with mem_ready=0 adds 1.
- Reset mid-instruction: the request deasserts immediately, no partial writeback occurs, and fetch restarts at the datapath's reset PC.
- illegal rises in the cycle after DECODE and holds until rst_n falls.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_LOAD, OP_STORE, OP_BRANCH);
  - funct3/funct7 constants;
  - the ALU_AND/OR/ADD/SUB codes;
  - the alusrca/alusrcb encodings;
  - the state enum (4 bits, RST_IDLE = 0).
- Sub-module alu_decode: combinational funct7/funct3 to aluctrl plus an r_legal flag, instantiated once for EXEC_R decode and legality.

## Test plan
- Zero-wait memory, instr=0x002081B3 (add x3,x1,x2) → state FETCH, DECODE, EXEC_R, R_WB. aluctrl=0010 in EXEC_R; regwrite=1 and retire=1 in cycle 4 only.
- instr=0x402081B3 (sub) → aluctrl=0110 in EXEC_R. Next, 0x0020E1B3 (or) → 0001, and 0x0020F1B3 (and) → 0000.
- instr=0x0080A283 (lw x5,8(x1)), mem_ready low for 2 cycles in MEM_RD → memread=1 and iord=1 held for 3 cycles, LOAD_WB has memtoreg=1, total 7 cycles.
- instr=0x0050A423 (sw x5,8(x1)), mem_ready stuck at 0 in FETCH for 3 cycles → irwrite=0 and pc_we=0 until ready. MEM_WR has memwrite=1, regwrite never rises.
- instr=0x00208863 (beq), zero=1 → pc_we=1 and pcsource=1 in BRANCH. With zero=0 → pc_we=0 in BRANCH.
- instr=0x00000013 (addi) → HALT and illegal=1 with all controls 0 for 10+ cycles. Pulling rst_n low mid-MEM_RD returns to RST_IDLE with memread=0 at once.
